fir_transpose_bank: RTL and testbench
=====================================

// Module: fir_transpose_bank
// PURPOSE
// - Parametrised successor of the fixed 12-bit transposed-form FIR: generic data/coef width and tap count,
//   sample-valid handshake, double-buffered (active/shadow) coefficient banks with glitch-free swap.
// - Sits between sample source and downstream DSP; coefficients written by host/testbench over the load port.
// PARAMETERS
// - DATA_W    12  signed sample width (Din, Dout)
// - COEF_W    12  signed coefficient width
// - TAPS      16  number of taps (>=2)
// - OUT_SHIFT 0   arithmetic right shift applied to accumulator before output (0..ACC_W-DATA_W)
// PORTS
// - Clk            in   1        clock, all logic on rising edge
// - Reset_n        in   1        asynchronous, active-low reset
// - Din            in   DATA_W   signed input sample
// - Din_valid      in   1        Din qualifier; filter advances only when high
// - Dout           out  DATA_W   signed filtered sample
// - Dout_valid     out  1        Dout qualifier
// - flush          in   1        sync clear of delay line (banks untouched)
// - load           in   1        write write_value into SHADOW bank at write_address
// - write_address  in   8        shadow write index
// - write_value    in   COEF_W   shadow write data
// - coef_swap      in   1        request shadow->active copy
// - swap_pending   out  1        swap requested, not yet applied
// - read_address   in   8        active-bank read index
// - read_value     out  COEF_W   active coef, registered (1-cycle latency)
// BEHAVIOUR
// - Reset (Reset_n=0, any time incl. mid-stream): delay line, both banks, Dout, read_value = 0;
//   Dout_valid=0, swap_pending=0, FSM -> RUN. Takes effect immediately, no clock needed.
// - Datapath (transposed): on Din_valid: y = c0*x + z0; z[k] <= c[k+1]*x + z[k+1]; z[TAPS-2] <= c[TAPS-1]*x.
//   Dout/Dout_valid registered: Dout_valid=1 exactly 1 cycle after a Din_valid cycle, else 0; Dout holds.
// - Din_valid=0: delay line frozen, no state change.
// - Widths: PROD_W=DATA_W+COEF_W, ACC_W=PROD_W+$clog2(TAPS); all signed two's complement, sign-extended.
// - Output: acc + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0), >>> OUT_SHIFT (round half up), then narrowed to DATA_W.
// - flush: clears z[] next edge; Dout_valid=0 that cycle; flush wins over simultaneous Din_valid (sample dropped).
// - load: write_address >= TAPS ignored (no wrap). Shadow writes never affect filtering until swap.
// - FSM {RUN, SWAP_WAIT}: coef_swap in RUN -> SWAP_WAIT, swap_pending=1.
//   SWAP_WAIT: on first cycle with Din_valid=0 copy shadow->active (all taps, one edge) -> RUN, swap_pending=0.
//   A sample in the same cycle as copy is impossible by construction; every sample sees one coherent bank.
//   coef_swap while SWAP_WAIT: no effect. load during SWAP_WAIT: allowed, included in copy if same-or-earlier edge.
// - read: read_address >= TAPS returns 0; read of address being swapped returns pre-swap value that cycle.
// CONFIGURATION
// - FIR_SAT_EN defined: narrowing saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
// - FIR_SAT_EN undefined: narrowing truncates (keeps low DATA_W bits, wraps). Default build: undefined.
// STRUCTURE
// - Package fir_pkg: acc_w()/prod_w() constant functions, typedef enum logic {RUN, SWAP_WAIT} fir_state_e.
// - Sub-module fir_coef_bank: shadow+active regs, load/read ports, swap copy; top holds FSM + datapath.
// TESTING (DATA_W=12, COEF_W=12, TAPS=16, OUT_SHIFT=0 unless noted)
// - Impulse: coefs c[k]=k+1, swap, Din=1 then 0 x16 (valid each cycle) -> Dout 1,2,...,16 then 0.
// - Valid gaps: same impulse with Din_valid toggling 1/0 -> identical Dout sequence on Dout_valid cycles only.
// - Swap under traffic: c=all 1, stream Din=1; load c=all 2, coef_swap with continuous valid -> swap_pending
//   stays 1, Dout 16; drop valid 1 cycle -> swap_pending 0, later outputs settle to 32.
// - Overflow: c=all 2047, Din=2047 x16 -> FIR_SAT_EN: Dout=2047; without: Dout = low 12 bits of 16*2047^2.
// - Rounding: OUT_SHIFT=1, c0=1 else 0, Din=3 -> Dout=2; Din=-3 -> Dout=-1.
// - Reset mid-stream: drop Reset_n during streaming -> Dout=0, Dout_valid=0, read_value of any addr = 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the transposed-form FIR with banked coefficients.
package fir_pkg;

   typedef enum logic {RUN = 1'b0, SWAP_WAIT = 1'b1} fir_state_e;

   function automatic int prod_w(input int data_w, input int coef_w);
      return data_w + coef_w;
   endfunction

   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: host writes the shadow bank, a single-edge copy
// moves it into the active bank that feeds the multipliers.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int COEF_W = 12,
   parameter int TAPS   = 16
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [7:0]               write_address,
   input  logic [COEF_W-1:0]        write_value,
   input  logic                     copy,
   input  logic [7:0]               read_address,
   output logic [COEF_W-1:0]        read_value,
   output logic [TAPS*COEF_W-1:0]   coef
);

   logic [COEF_W-1:0] shadow_r [TAPS];
   logic [COEF_W-1:0] active_r [TAPS];
   logic [COEF_W-1:0] read_sel_s;
   logic [COEF_W-1:0] read_value_r;

   // Shadow bank write; addresses past the last tap match nothing and are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) shadow_r[i] <= {COEF_W{1'b0}};
      end else begin
         for (int i = 0; i < TAPS; i++) begin
            if (load && (write_address == 8'(i))) shadow_r[i] <= write_value;
         end
      end
   end

   // Active bank copy; a load on the copy edge is forwarded so it is not lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) active_r[i] <= {COEF_W{1'b0}};
      end else if (copy) begin
         for (int i = 0; i < TAPS; i++) begin
            active_r[i] <= (load && (write_address == 8'(i))) ? write_value : shadow_r[i];
         end
      end
   end

   // Read mux over the active bank, zero for out-of-range addresses
   always_comb begin
      read_sel_s = {COEF_W{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
         read_sel_s = read_sel_s | ((read_address == 8'(i)) ? active_r[i] : {COEF_W{1'b0}});
      end
   end

   // Registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) read_value_r <= {COEF_W{1'b0}};
      else        read_value_r <= read_sel_s;
   end

   // Flatten the active bank for the datapath
   always_comb begin
      coef = {(TAPS*COEF_W){1'b0}};
      for (int i = 0; i < TAPS; i++) coef[i*COEF_W +: COEF_W] = active_r[i];
   end

   assign read_value = read_value_r;

endmodule

// File: rtl/fir_transpose_bank.sv
// Transposed-form FIR with valid handshake and glitch-free coefficient bank swap.
// Define FIR_SAT_EN to saturate the output narrowing instead of wrapping.
module fir_transpose_bank
   import fir_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int COEF_W    = 12,
   parameter int TAPS      = 16,
   parameter int OUT_SHIFT = 0
)
(
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [DATA_W-1:0]   Din,
   input  logic                Din_valid,
   output logic [DATA_W-1:0]   Dout,
   output logic                Dout_valid,
   input  logic                flush,
   input  logic                load,
   input  logic [7:0]          write_address,
   input  logic [COEF_W-1:0]   write_value,
   input  logic                coef_swap,
   output logic                swap_pending,
   input  logic [7:0]          read_address,
   output logic [COEF_W-1:0]   read_value
);

   localparam int PROD_W = prod_w(DATA_W, COEF_W);
   localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
   localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] RND = (OUT_SHIFT > 0) ?
      ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : {(ACC_W+1){1'b0}};
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

   fir_state_e                 state_r, state_next_s;
   logic                       copy_s;
   logic                       swap_pending_r;
   logic [TAPS*COEF_W-1:0]     coef_s;
   logic signed [PROD_W-1:0]   prod_raw_s [TAPS];
   logic signed [ACC_W-1:0]    prod_s [TAPS];
   logic signed [ACC_W-1:0]    z_r [TAPS-1];
   logic signed [ACC_W-1:0]    acc_s;
   logic signed [ACC_W:0]      rnd_s;
   logic signed [ACC_W:0]      shifted_s;
   logic signed [DATA_W-1:0]   narrow_s;
   logic [DATA_W-1:0]          dout_r;
   logic                       dout_valid_r;

   fir_coef_bank #(.COEF_W(COEF_W), .TAPS(TAPS)) u_bank (
      .clk           (Clk),
      .rst_n         (Reset_n),
      .load          (load),
      .write_address (write_address),
      .write_value   (write_value),
      .copy          (copy_s),
      .read_address  (read_address),
      .read_value    (read_value),
      .coef          (coef_s)
   );

   // Swap control: the copy waits for an idle input cycle so no sample sees a mixed bank
   always_comb begin
      state_next_s = state_r;
      copy_s       = 1'b0;
      case (state_r)
         RUN: begin
            if (coef_swap) state_next_s = SWAP_WAIT;
            else           state_next_s = RUN;
         end
         SWAP_WAIT: begin
            if (!Din_valid) begin
               copy_s       = 1'b1;
               state_next_s = RUN;
            end else begin
               state_next_s = SWAP_WAIT;
            end
         end
         default: state_next_s = RUN;
      endcase
   end

   // Swap state register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r        <= RUN;
         swap_pending_r <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         swap_pending_r <= (state_next_s == SWAP_WAIT);
      end
   end

   // Per-tap products, sign-extended to accumulator width
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         prod_raw_s[k] = $signed(Din) * $signed(coef_s[k*COEF_W +: COEF_W]);
         prod_s[k]     = {{(ACC_W-PROD_W){prod_raw_s[k][PROD_W-1]}}, prod_raw_s[k]};
      end
   end

   // Output tap, round-half-up shift and narrowing
   always_comb begin
      acc_s     = prod_s[0] + z_r[0];
      rnd_s     = {acc_s[ACC_W-1], acc_s} + RND;
      shifted_s = rnd_s >>> OUT_SHIFT;
      narrow_s  = shifted_s[DATA_W-1:0];
`ifdef FIR_SAT_EN
      if (shifted_s > SAT_MAX)      narrow_s = SAT_MAX[DATA_W-1:0];
      else if (shifted_s < SAT_MIN) narrow_s = SAT_MIN[DATA_W-1:0];
      else                          narrow_s = shifted_s[DATA_W-1:0];
`endif
   end

`ifndef FIR_SAT_EN
   logic unused_high_bits_s;
   assign unused_high_bits_s = ^{shifted_s[ACC_W:DATA_W], SAT_MAX, SAT_MIN};
`endif

   // Delay line and registered output; flush drops any coincident sample
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < TAPS-1; k++) z_r[k] <= {ACC_W{1'b0}};
         dout_r       <= {DATA_W{1'b0}};
         dout_valid_r <= 1'b0;
      end else if (flush) begin
         for (int k = 0; k < TAPS-1; k++) z_r[k] <= {ACC_W{1'b0}};
         dout_valid_r <= 1'b0;
      end else if (Din_valid) begin
         for (int k = 0; k < TAPS-2; k++) z_r[k] <= prod_s[k+1] + z_r[k+1];
         z_r[TAPS-2]  <= prod_s[TAPS-1];
         dout_r       <= narrow_s;
         dout_valid_r <= 1'b1;
      end else begin
         dout_valid_r <= 1'b0;
      end
   end

   assign Dout         = dout_r;
   assign Dout_valid   = dout_valid_r;
   assign swap_pending = swap_pending_r;

endmodule

// File: tb/tb_fir_transpose_bank.sv
// Bench for fir_transpose_bank: two instances (OUT_SHIFT 0 and 1) share stimulus and are
// compared each cycle against a sample-history model plus literal expectations.
module tb_fir_transpose_bank;

   logic               Clk = 1'b0;
   logic               Reset_n;
   logic signed [11:0] Din = 12'sd0;
   logic               Din_valid = 1'b0;
   logic               flush = 1'b0;
   logic               load = 1'b0;
   logic [7:0]         write_address = 8'd0;
   logic [11:0]        write_value = 12'd0;
   logic               coef_swap = 1'b0;
   logic [7:0]         read_address = 8'd0;

   logic signed [11:0] dout0, dout1, read0, read1;
   logic               valid0, valid1, pend0, pend1;

   int tests_run = 0;
   int tests_failed = 0;

   fir_transpose_bank #(.DATA_W(12), .COEF_W(12), .TAPS(16), .OUT_SHIFT(0)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Din(Din), .Din_valid(Din_valid),
      .Dout(dout0), .Dout_valid(valid0), .flush(flush), .load(load),
      .write_address(write_address), .write_value(write_value),
      .coef_swap(coef_swap), .swap_pending(pend0),
      .read_address(read_address), .read_value(read0));

   fir_transpose_bank #(.DATA_W(12), .COEF_W(12), .TAPS(16), .OUT_SHIFT(1)) dut_r (
      .Clk(Clk), .Reset_n(Reset_n), .Din(Din), .Din_valid(Din_valid),
      .Dout(dout1), .Dout_valid(valid1), .flush(flush), .load(load),
      .write_address(write_address), .write_value(write_value),
      .coef_swap(coef_swap), .swap_pending(pend1),
      .read_address(read_address), .read_value(read1));

   always #5 Clk = ~Clk;

   // ---------------- model ----------------
   int shadow_m [16];
   int active_m [16];
   int hx [16];
   int hc [16][16];
   bit pend_m = 1'b0;
   bit exp_v = 1'b0;
   logic signed [11:0] exp_d0 = 12'sd0, exp_d1 = 12'sd0, exp_rd = 12'sd0;

   function automatic logic signed [11:0] narrow(input longint v);
`ifdef FIR_SAT_EN
      if (v > 64'sd2047)  return 12'sd2047;
      if (v < -64'sd2048) return -12'sd2048;
`endif
      return v[11:0];
   endfunction

   initial begin
      forever begin
         @(posedge Clk or negedge Reset_n);
         if (!Reset_n) begin
            for (int i = 0; i < 16; i++) begin
               shadow_m[i] = 0; active_m[i] = 0; hx[i] = 0;
               for (int j = 0; j < 16; j++) hc[i][j] = 0;
            end
            pend_m = 1'b0; exp_v = 1'b0;
            exp_d0 = 12'sd0; exp_d1 = 12'sd0; exp_rd = 12'sd0;
         end else begin
            exp_rd = (int'(read_address) < 16) ? 12'(active_m[int'(read_address)]) : 12'sd0;
            if (Din_valid && !flush) begin
               longint sum;
               for (int i = 15; i > 0; i--) begin
                  hx[i] = hx[i-1];
                  for (int j = 0; j < 16; j++) hc[i][j] = hc[i-1][j];
               end
               hx[0] = int'(Din);
               for (int j = 0; j < 16; j++) hc[0][j] = active_m[j];
               sum = 0;
               for (int k = 0; k < 16; k++) sum += longint'(hc[k][k]) * longint'(hx[k]);
               exp_d0 = narrow(sum);
               exp_d1 = narrow((sum + 64'sd1) >>> 1);
               exp_v  = 1'b1;
            end else begin
               exp_v = 1'b0;
               if (flush) begin
                  for (int i = 0; i < 16; i++) begin
                     hx[i] = 0;
                     for (int j = 0; j < 16; j++) hc[i][j] = 0;
                  end
               end
            end
            if (load && int'(write_address) < 16)
               shadow_m[int'(write_address)] = int'($signed(write_value));
            if (pend_m) begin
               if (!Din_valid) begin
                  for (int j = 0; j < 16; j++) active_m[j] = shadow_m[j];
                  pend_m = 1'b0;
               end
            end else if (coef_swap) begin
               pend_m = 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge Clk);
         if (Reset_n === 1'b1 || Reset_n === 1'b0) begin
            check("dout0", dout0, exp_d0);
            check("dout1", dout1, exp_d1);
            check("valid0", {31'd0, valid0}, {31'd0, exp_v});
            check("valid1", {31'd0, valid1}, {31'd0, exp_v});
            check("pend0", {31'd0, pend0}, {31'd0, pend_m});
            check("pend1", {31'd0, pend1}, {31'd0, pend_m});
            check("read0", read0, exp_rd);
            check("read1", read1, exp_rd);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_coef(input int addr, input int val);
      load = 1'b1; write_address = 8'(addr); write_value = 12'(val);
      step();
      load = 1'b0;
   endtask

   task automatic load_all(input int val);
      for (int k = 0; k < 16; k++) load_coef(k, val);
   endtask

   task automatic swap_now();
      coef_swap = 1'b1; Din_valid = 1'b0;
      step();
      coef_swap = 1'b0;
      step();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic send(input int x, input bit v);
      Din = 12'(x); Din_valid = v;
      step();
      Din_valid = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b1;
      #2 Reset_n = 1'b0;
      #1;
      check("reset_dout", dout0, 0);
      check("reset_valid", {31'd0, valid0}, 0);
      check("reset_pend", {31'd0, pend0}, 0);
      check("reset_read", read0, 0);
      step(); step();
      Reset_n = 1'b1;
      step();

      // Impulse with c[k] = k+1; shadow writes invisible before swap
      for (int k = 0; k < 16; k++) load_coef(k, k + 1);
      read_address = 8'd3;
      step();
      check("shadow_invisible", read0, 0);
      coef_swap = 1'b1;
      step();
      check("swap_pending_set", {31'd0, pend0}, 1);
      coef_swap = 1'b0;
      step();
      check("swap_pending_clr", {31'd0, pend0}, 0);
      step();
      check("read_active3", read0, 4);
      read_address = 8'd200;
      step();
      check("read_oob", read0, 0);

      send(1, 1'b1);
      check("impulse_0", dout0, 1);
      for (int i = 1; i < 16; i++) begin
         send(0, 1'b1);
         check("impulse_k", dout0, i + 1);
      end
      send(0, 1'b1);
      check("impulse_tail", dout0, 0);

      // Same impulse with valid gaps
      do_flush();
      send(1, 1'b1);
      check("gap_0", dout0, 1);
      for (int i = 1; i < 16; i++) begin
         send(0, 1'b0);
         check("gap_idle_valid", {31'd0, valid0}, 0);
         send(0, 1'b1);
         check("gap_k", dout0, i + 1);
      end

      // Swap under continuous traffic
      load_all(1);
      swap_now();
      do_flush();
      for (int i = 0; i < 16; i++) send(1, 1'b1);
      check("ones_16", dout0, 16);
      for (int k = 0; k < 16; k++) begin
         load = 1'b1; write_address = 8'(k); write_value = 12'd2;
         Din = 12'sd1; Din_valid = 1'b1;
         step();
      end
      load = 1'b0;
      coef_swap = 1'b1;
      for (int i = 0; i < 4; i++) step();
      coef_swap = 1'b0;
      step();
      check("pending_held", {31'd0, pend0}, 1);
      check("dout_old_bank", dout0, 16);
      Din_valid = 1'b0;
      step();
      check("pending_done", {31'd0, pend0}, 0);
      for (int i = 0; i < 16; i++) send(1, 1'b1);
      check("twos_32", dout0, 32);

      // Flush beats a coincident sample
      flush = 1'b1; Din = 12'sd1; Din_valid = 1'b1;
      step();
      flush = 1'b0; Din_valid = 1'b0;
      check("flush_valid", {31'd0, valid0}, 0);
      send(1, 1'b1);
      check("after_flush", dout0, 2);

      // Overflow: 16 * 2047^2
      load_all(2047);
      swap_now();
      do_flush();
      for (int i = 0; i < 16; i++) send(2047, 1'b1);
`ifdef FIR_SAT_EN
      check("overflow", dout0, 2047);
`else
      check("overflow", dout0, 16);
`endif

      // Rounding with c0=1; out-of-range loads must not wrap
      load_coef(0, 1);
      for (int k = 1; k < 16; k++) load_coef(k, 0);
      load_coef(16, 5);
      load_coef(255, 7);
      swap_now();
      read_address = 8'd0;
      step();
      check("read_c0", read0, 1);
      do_flush();
      send(3, 1'b1);
      check("round_pos", dout1, 2);
      check("unshifted_pos", dout0, 3);
      send(-3, 1'b1);
      check("round_neg", dout1, -1);

      // Reset in the middle of a stream
      send(5, 1'b1);
      Din_valid = 1'b1; Din = 12'sd6;
      Reset_n = 1'b0;
      #1;
      check("midreset_dout", dout0, 0);
      check("midreset_valid", {31'd0, valid0}, 0);
      check("midreset_read", read0, 0);
      Din_valid = 1'b0;
      read_address = 8'd3;
      step();
      check("midreset_read3", read0, 0);
      Reset_n = 1'b1;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
